// File: rtl/wb_mdio_pkg.sv
// Shared constants, FSM encoding and frame builder for the Wishbone MDIO master.
package wb_mdio_pkg;

  localparam logic [1:0] ADR_CMD    = 2'd0;
  localparam logic [1:0] ADR_WDATA  = 2'd1;
  localparam logic [1:0] ADR_RDATA  = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  localparam logic [1:0] MDIO_ST  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  // Bit indices within the 64-bit frame where each phase ends.
  localparam logic [5:0] LAST_PRE   = 6'd31;
  localparam logic [5:0] LAST_HDR   = 6'd45;
  localparam logic [5:0] LAST_TA    = 6'd47;
  localparam logic [5:0] FIRST_DATA = 6'd48;
  localparam logic [5:0] LAST_BIT   = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Read frames carry ones after the header; the line is released there anyway.
  function automatic logic [63:0] build_frame(input logic is_read, input logic [4:0] phy,
                                              input logic [4:0] reg_addr, input logic [15:0] data);
    return {32'hFFFF_FFFF, MDIO_ST, (is_read ? OP_READ : OP_WRITE), phy, reg_addr,
            (is_read ? 2'b11 : TA_WRITE), (is_read ? 16'hFFFF : data)};
  endfunction

endpackage

// File: rtl/wb_mdio_clkgen.sv
// MDC divider: toggles mdc every CLK_DIV+1 cycles while enabled and exposes
// the edges one cycle early so data can change on the very edge mdc moves.
module mdio_clkgen #(
  parameter int CLK_DIV = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV);

  logic [CW-1:0] cnt_r;
  logic          mdc_r;
  logic          tick_s;

  assign tick_s   = enable && (cnt_r == DIV_MAX);
  assign rise_stb = tick_s && !mdc_r;
  assign fall_stb = tick_s && mdc_r;
  assign mdc      = mdc_r;

  // Half-period counter and mdc toggle; dropping enable parks mdc low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      mdc_r <= 1'b0;
    end else if (!enable) begin
      cnt_r <= {CW{1'b0}};
      mdc_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r <= {CW{1'b0}};
      mdc_r <= ~mdc_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/wb_mdio.sv
// Wishbone classic responder driving one IEEE 802.3 clause-22 MDIO frame per CMD write.
module wb_mdio
  import wb_mdio_pkg::*;
#(
  parameter int CLK_DIV = 9
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  state_e        state_r, state_s;
  logic          ack_r, busy_r, done_r, op_read_r, mdio_r, oe_r;
  logic [31:0]   dat_r;
  logic [15:0]   wdata_r, rdata_r, rx_r;
  logic [63:0]   tx_r;
  logic [5:0]    bit_cnt_r;
  logic          req_s, wr_s, cmd_start_s, last_fall_s, in_frame_s;
  logic          rise_s, fall_s, mdc_s;
  logic          unused_s;

  assign req_s       = wb_cyc_i && wb_stb_i && !ack_r;
  // Writes commit at the end of the ack cycle, so busy follows the ack.
  assign wr_s        = ack_r && wb_cyc_i && wb_stb_i && wb_we_i && (wb_sel_i == 4'hF);
  assign cmd_start_s = wr_s && (wb_adr_i[3:2] == ADR_CMD) && !busy_r;
  assign last_fall_s = fall_s && (bit_cnt_r == LAST_BIT);
  assign in_frame_s  = (state_r == ST_PRE) || (state_r == ST_HDR) ||
                       (state_r == ST_TA)  || (state_r == ST_DATA);
  assign unused_s    = ^{wb_adr_i[1:0], wb_dat_i[31:16], tx_r[63]};

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .enable   (in_frame_s),
    .mdc      (mdc_s),
    .rise_stb (rise_s),
    .fall_stb (fall_s)
  );

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Phase transitions happen on the mdc falling edge that ends each phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (cmd_start_s) state_s = ST_PRE; else state_s = ST_IDLE;
      ST_PRE:  if (fall_s && bit_cnt_r == LAST_PRE) state_s = ST_HDR; else state_s = ST_PRE;
      ST_HDR:  if (fall_s && bit_cnt_r == LAST_HDR) state_s = ST_TA; else state_s = ST_HDR;
      ST_TA:   if (fall_s && bit_cnt_r == LAST_TA) state_s = ST_DATA; else state_s = ST_TA;
      ST_DATA: if (last_fall_s) state_s = ST_DONE; else state_s = ST_DATA;
      ST_DONE: if (cmd_start_s) state_s = ST_PRE; else state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus side: ack, registered read data, WDATA and the sticky done flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r   <= 1'b0;
      dat_r   <= 32'h0000_0000;
      wdata_r <= 16'h0000;
      done_r  <= 1'b0;
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        case (wb_adr_i[3:2])
          ADR_WDATA:  dat_r <= {16'h0000, wdata_r};
          ADR_RDATA:  dat_r <= {16'h0000, rdata_r};
          ADR_STATUS: dat_r <= {30'h0000_0000, done_r, busy_r};
          default:    dat_r <= 32'h0000_0000;
        endcase
      end else begin
        dat_r <= 32'h0000_0000;
      end
      if (wr_s && wb_adr_i[3:2] == ADR_WDATA) wdata_r <= wb_dat_i[15:0];
      // Completion beats a simultaneous clear.
      if (last_fall_s) done_r <= 1'b1;
      else if (wr_s && wb_adr_i[3:2] == ADR_STATUS && wb_dat_i[1]) done_r <= 1'b0;
    end
  end

  // Line side: frame shift register, bit counter, drive enable and receive capture.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_r      <= 64'h0;
      bit_cnt_r <= 6'd0;
      mdio_r    <= 1'b1;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      op_read_r <= 1'b0;
      rx_r      <= 16'h0000;
      rdata_r   <= 16'h0000;
    end else begin
      if (cmd_start_s) begin
        tx_r      <= build_frame(wb_dat_i[10], wb_dat_i[9:5], wb_dat_i[4:0], wdata_r);
        bit_cnt_r <= 6'd0;
        mdio_r    <= 1'b1;
        oe_r      <= 1'b1;
        busy_r    <= 1'b1;
        op_read_r <= wb_dat_i[10];
        rx_r      <= 16'h0000;
      end else if (last_fall_s) begin
        bit_cnt_r <= 6'd0;
        mdio_r    <= 1'b1;
        oe_r      <= 1'b0;
        busy_r    <= 1'b0;
      end else if (fall_s) begin
        tx_r      <= {tx_r[62:0], 1'b0};
        mdio_r    <= tx_r[62];
        bit_cnt_r <= bit_cnt_r + 6'd1;
        // A read releases the line from the first turnaround bit onward.
        oe_r      <= !(op_read_r && (bit_cnt_r >= LAST_HDR));
      end else if (rise_s && bit_cnt_r >= FIRST_DATA) begin
        rx_r <= {rx_r[14:0], mdio_i};
      end else begin
        rx_r <= rx_r;
      end
      if (state_r == ST_DONE && op_read_r) rdata_r <= rx_r;
    end
  end

  assign wb_ack_o  = ack_r;
  assign wb_dat_o  = dat_r;
  assign mdc_o     = mdc_s;
  assign mdio_o    = mdio_r;
  assign mdio_oe_o = oe_r;

endmodule

// File: tb/tb_wb_mdio.sv
// Randomised scoreboard bench for wb_mdio with an MDIO PHY model and a register model.
module tb_wb_mdio;

  localparam logic [1:0] A_CMD = 2'd0, A_WDATA = 2'd1, A_RDATA = 2'd2, A_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] dat_o;
  logic        ack, mdc, mdio_o, mdio_oe;
  logic        mdio_i = 1'b1;

  always #5 clk = ~clk;

  wb_mdio #(.CLK_DIV(9)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .mdc_o(mdc), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe), .mdio_i(mdio_i)
  );

  typedef struct {
    logic        is_read;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // register model
  logic [15:0] wdata_m = 16'h0, rdata_m = 16'h0;
  logic        done_m = 1'b0;

  // line monitor / PHY model state
  int          cyc_cnt = 0, rise_cnt = 0, frame_base = 0;
  int          first_rise_cyc = 0, second_rise_cyc = 0, last_fall_cyc = 0, last_ack_cyc = 0;
  int          timing_viol = 0;
  logic [63:0] cap_bits = 64'h0, cap_oe = 64'h0;
  logic [15:0] phy_data = 16'h0;
  logic        phy_read = 1'b0;
  logic        prev_ack = 1'b0, prev_mdc = 1'b0, prev_mdio = 1'b1, prev_oe = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    sb_t e;
    int  idx;
    if (ack) begin
      last_ack_cyc = cyc_cnt;
      if (prev_ack) check("ack_back_to_back", 64'd1, 64'd0);
      if (sb_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
      else begin
        e = sb_q.pop_front();
        if (e.is_read) check(e.name, 64'(dat_o), 64'(e.exp));
      end
    end
    idx = rise_cnt - frame_base;
    if (!prev_mdc && mdc) begin
      if (idx >= 0 && idx < 64) begin
        cap_bits[63-idx] = mdio_o;
        cap_oe[63-idx]   = mdio_oe;
      end
      if (idx == 0) first_rise_cyc = cyc_cnt;
      if (idx == 1) second_rise_cyc = cyc_cnt;
      rise_cnt++;
    end
    if (prev_mdc && !mdc) begin
      last_fall_cyc = cyc_cnt;
      idx = rise_cnt - frame_base;
      mdio_i = (phy_read && idx >= 48 && idx < 64) ? phy_data[63-idx] : 1'b1;
    end
    if (!rst && ({mdio_o, mdio_oe} !== {prev_mdio, prev_oe}) && !(prev_mdc && !mdc) &&
        !(!prev_oe && mdio_oe && mdio_o === prev_mdio))
      timing_viol++;
    prev_ack = ack; prev_mdc = mdc; prev_mdio = mdio_o; prev_oe = mdio_oe;
  end

  task automatic bus(input logic w, input logic [1:0] ra, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp, input string name);
    sb_t e;
    int  n;
    e.is_read = !w; e.exp = exp; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {ra, 2'b00}; dat_i = d; sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    check({name, "_ack_latency"}, 64'(n), 64'd1);
    if (!ack) sb_q.delete();
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ra, input logic [31:0] d);
    bus(1'b1, ra, d, 4'hF, 32'h0, "write");
    if (ra == A_WDATA) wdata_m = d[15:0];
    if (ra == A_STATUS && d[1]) done_m = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ra, input logic [31:0] exp, input string name);
    bus(1'b0, ra, 32'h0, 4'hF, exp, name);
  endtask

  logic        f_rd;
  logic [4:0]  f_phy, f_reg;
  logic [15:0] f_wd, f_pd;
  int          f_ack;

  task automatic start_frame(input logic is_rd, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] wd, input logic [15:0] pd);
    f_rd = is_rd; f_phy = phy; f_reg = ra; f_wd = wd; f_pd = pd;
    wr(A_WDATA, {16'h0, wd});
    frame_base = rise_cnt; phy_read = is_rd; phy_data = pd;
    wr(A_CMD, {21'h0, is_rd, phy, ra});
    f_ack = last_ack_cyc;
  endtask

  task automatic finish_frame();
    int          n;
    logic [63:0] exp_bits, exp_oe;
    n = 0;
    while ((rise_cnt - frame_base) < 64 && n < 4000) begin @(posedge clk); n++; end
    if (n >= 4000) check("frame_timeout", 64'(rise_cnt - frame_base), 64'd64);
    repeat (15) @(posedge clk);
    // 32 preamble ones, ST, OP, PHYAD, REGAD, TA, DATA -- all MSB first
    exp_bits = {32'hFFFF_FFFF, 2'b01, (f_rd ? 2'b10 : 2'b01), f_phy, f_reg, 2'b10, f_wd};
    exp_oe   = f_rd ? ~64'h3FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (f_rd) check("frame_header", cap_bits[63:18], exp_bits[63:18]);
    else      check("frame_bits", cap_bits, exp_bits);
    check("frame_oe", cap_oe, exp_oe);
    check("first_mdc_rise", 64'(first_rise_cyc - f_ack), 64'd11);
    check("mdc_period", 64'(second_rise_cyc - first_rise_cyc), 64'd20);
    check("frame_length", 64'(last_fall_cyc - f_ack), 64'd1281);
    done_m = 1'b1;
    if (f_rd) rdata_m = f_pd;
    rd(A_STATUS, 32'h2, "status_after_frame");
    rd(A_RDATA, {16'h0, rdata_m}, "rdata_after_frame");
  endtask

  initial begin
    int          n, r0;
    logic [3:0]  pat;
    logic        rr;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 4'h0; dat_i = 32'h0; sel = 4'h0;
    repeat (3) @(posedge clk); #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_mdio", 64'(mdio_o), 64'd1);
    check("rst_oe", 64'(mdio_oe), 64'd0);
    rst = 1'b0;
    rd(A_WDATA, 32'h0, "rst_wdata");
    rd(A_RDATA, 32'h0, "rst_rdata");
    rd(A_STATUS, 32'h0, "rst_status");

    // write frame: WDATA=0xBEEF, phy 1, reg 4
    start_frame(1'b0, 5'd1, 5'h04, 16'hBEEF, 16'h0);
    finish_frame();
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, 32'h0, "status_w1c");

    // read frame: phy 3, reg 2, PHY answers 0x0141
    start_frame(1'b1, 5'd3, 5'h02, 16'h0, 16'h0141);
    finish_frame();
    wr(A_STATUS, 32'h2);

    // CMD and WDATA written mid-frame must not disturb the running frame
    start_frame(1'b0, 5'd5, 5'($urandom_range(0, 31)), 16'($urandom), 16'h0);
    repeat (200) @(posedge clk);
    wr(A_CMD, {21'h0, 1'b1, 5'd7, 5'h01});
    wr(A_WDATA, {16'h0, ~f_wd});
    rd(A_STATUS, 32'h1, "status_busy");
    rd(A_WDATA, {16'h0, wdata_m}, "wdata_while_busy");
    finish_frame();
    repeat (1500) @(posedge clk);
    check("no_second_frame", 64'(rise_cnt - frame_base), 64'd64);

    // random frames
    for (int i = 0; i < 4; i++) begin
      rr = 1'($urandom_range(0, 1));
      start_frame(rr, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
      finish_frame();
    end

    // stb held for four cycles: ack 0,1,0,1
    sb_q.push_back('{1'b0, 32'h2, "status_hold_1"});
    sb_q.push_back('{1'b0, 32'h2, "status_hold_2"});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {A_STATUS, 2'b00}; sel = 4'hF;
    pat[3] = ack;
    for (int k = 2; k >= 0; k--) begin @(posedge clk); #1; pat[k] = ack; end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    check("ack_pattern", 64'(pat), 64'h5);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, 32'h0, "status_cleared");

    // register map corners
    bus(1'b1, A_WDATA, 32'h0000_1234, 4'h3, 32'h0, "partial_sel_write");
    rd(A_WDATA, {16'h0, wdata_m}, "partial_sel_ignored");
    wr(A_WDATA, 32'hFFFF_FFFF);
    rd(A_WDATA, 32'h0000_FFFF, "wdata_upper_zero");
    wr(A_RDATA, 32'h0000_5A5A);
    rd(A_RDATA, {16'h0, rdata_m}, "rdata_ro");
    rd(A_CMD, 32'h0, "cmd_reads_zero");

    // reset in the middle of a read frame
    start_frame(1'b1, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom));
    n = 0;
    while ((rise_cnt - frame_base) < 40 && n < 3000) begin @(negedge clk); n++; end
    check("reach_period_40", 64'(n < 3000), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_mdc", 64'(mdc), 64'd0);
    check("midrst_oe", 64'(mdio_oe), 64'd0);
    @(posedge clk); #1;
    check("midrst_mdc_hold", 64'(mdc), 64'd0);
    check("midrst_ack", 64'(ack), 64'd0);
    rst = 1'b0;
    wdata_m = 16'h0; rdata_m = 16'h0; done_m = 1'b0;
    r0 = rise_cnt;
    repeat (300) @(posedge clk);
    check("no_mdc_after_reset", 64'(rise_cnt), 64'(r0));
    rd(A_STATUS, 32'h0, "midrst_status");
    rd(A_RDATA, 32'h0, "midrst_rdata");
    rd(A_WDATA, 32'h0, "midrst_wdata");

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("mdio_change_timing", 64'(timing_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mdio.md
WB_MDIO -- requirements
Module: wb_mdio

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 9, meaning MDC half-period in wb_clk_i cycles minus one (50 MHz -> 2.5 MHz MDC).
REQ-002 The block SHALL have port wb_clk_i  in  1  single system clock; all logic on rising edge.
REQ-003 The block SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port wb_adr_i  in  4  byte address; only bits [3:2] decoded.
REQ-005 The block SHALL have port wb_dat_i  in  32  write data.
REQ-006 The block SHALL have port wb_sel_i  in  4  byte enables; all four are required for a write to take effect.
REQ-007 The block SHALL have ports wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone classic responder controls.
REQ-008 The block SHALL have port wb_dat_o  out  32  read data.
REQ-009 The block SHALL have port wb_ack_o  out  1  transfer acknowledge.
REQ-010 The block SHALL have port mdc_o  out  1  MDIO management clock.
REQ-011 The block SHALL have ports mdio_o  out  1 and mdio_oe_o  out  1  MDIO drive value and enable; top-level tristate is external.
REQ-012 The block SHALL have port mdio_i  in  1  sampled MDIO pin.

Function
REQ-013 Register map: 0x0 CMD (W: [4:0] reg, [9:5] phy, [10] op 1=read/0=write; write starts a frame); 0x4 WDATA [15:0] R/W; 0x8 RDATA [15:0] RO; 0xC STATUS ([0] busy RO, [1] done sticky, write-1-to-clear).
REQ-014 Unused read bits SHALL return 0; writes to RO fields SHALL be ignored.
REQ-015 wb_ack_o SHALL assert exactly one cycle after wb_cyc_i&wb_stb_i is sampled high with ack low, for one cycle; ack is never asserted in two consecutive cycles.
REQ-016 Read data SHALL be valid in the ack cycle.
REQ-017 A CMD write while busy=1 SHALL be acknowledged and ignored.
REQ-018 mdc_o SHALL toggle every CLK_DIV+1 cycles only while busy; it SHALL idle low.
REQ-019 mdio_o/mdio_oe_o SHALL change only in the cycle mdc_o falls; mdio_i SHALL be sampled in the cycle mdc_o rises.
REQ-020 FSM states: IDLE -> PRE (32 ones) -> HDR (ST 01, OP 01 write/10 read, PHY[4:0], REG[4:0], MSB first) -> TA -> DATA (16 bits MSB first) -> DONE -> IDLE.
REQ-021 TA for write SHALL drive 1 then 0; for read mdio_oe_o SHALL be 0 for TA and DATA.
REQ-022 Read data SHALL be shifted into RDATA and written only in DONE; RDATA is unchanged by write frames.
REQ-023 DONE SHALL set done=1, clear busy, leave mdc_o low and mdio_oe_o 0, and return to IDLE next cycle.
REQ-024 A frame SHALL be exactly 64 MDC periods; busy SHALL rise the cycle after the CMD ack.
REQ-025 If a W1C of done and frame completion coincide, done SHALL end at 1.
REQ-026 WDATA SHALL be latched into the shift register at frame start; WDATA writes while busy do not affect the active frame.

Reset
REQ-027 On wb_rst_i asserted, any cycle: FSM=IDLE, wb_ack_o=0, wb_dat_o=0, mdc_o=0, mdio_o=1, mdio_oe_o=0, WDATA=0, RDATA=0, busy=0, done=0, counters=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately with no further MDC edges.

Structure
REQ-029 Register offsets, opcode/ST constants, frame-length constants, and the FSM state encoding SHALL live in shared package wb_mdio_pkg.
REQ-030 MDC divider and edge strobes SHALL be a sub-module mdio_clkgen (outputs mdc, rise_stb, fall_stb; input enable).

Verification
REQ-031 Write WDATA=0xBEEF, CMD phy=1 reg=0x04 write -> MDIO serial stream 32x1, 01, 01, 00001, 00100, 10, 1011111011101111; done=1 after 64 MDC periods.
REQ-032 CMD phy=3 reg=0x02 read, PHY model drives 0x0141 after TA -> mdio_oe_o=0 from TA start, RDATA=0x0141, STATUS=0x2.
REQ-033 CMD written while busy (phy=7) -> ack given, frame still carries the original phy address, no second frame.
REQ-034 wb_rst_i pulsed at MDC period 40 -> mdc_o=0, mdio_oe_o=0, busy=0, RDATA=0 that cycle and after.
REQ-035 CLK_DIV=9 -> MDC period 20 cycles, frame 1280 cycles from busy rise to done.
REQ-036 Back-to-back stb held high 4 cycles -> ack pattern 0,1,0,1; W1C STATUS=0x2 -> done reads 0.
